// File: rtl/velocity_sample_ctrl.sv
// velocity_sample_ctrl: samples position on a programmable tick and emits |curr-prev|*3.625 on valid/ready.
// Optional macro SATURATE_EN clamps overflowing results to all-ones instead of wrapping.
module velocity_sample_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0]     i_value,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_ovf,
  output logic                 o_overrun,
  output logic                 o_busy
);
  typedef enum logic [2:0] {IDLE, WAIT, DIFF, SCALE, OUT} state_t;
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, period;
  logic [WIDTH-1:0]     prev_q, prev_d, curr_q, curr_d, diff_q, diff_d, value_q, value_d;
  logic                 prime_q, prime_d, ovf_q, ovf_d, overrun_q, overrun_d, tick, full_ovf;
  logic [WIDTH+2:0]     full;

  always_comb begin
    period   = (i_period == '0) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : i_period;
    tick     = i_en && (cnt_q >= period - 1'b1);
    cnt_d    = (!i_en || tick) ? '0 : cnt_q + 1'b1;
    // 2d + d + d/2 + d/8 = 3.625d, each shift floored on its own
    full     = {2'b0, diff_q, 1'b0} + {3'b0, diff_q} + {4'b0, diff_q[WIDTH-1:1]} + {6'b0, diff_q[WIDTH-1:3]};
    full_ovf = |full[WIDTH+2:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    curr_d    = curr_q;
    diff_d    = diff_q;
    value_d   = value_q;
    ovf_d     = ovf_q;
    prime_d   = prime_q;
    overrun_d = tick && (state_q != WAIT);
    if (!i_en) begin
      state_d = IDLE;
      prime_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: if (tick) begin
          curr_d  = i_value;
          prev_d  = curr_q;
          prime_d = 1'b1;
          state_d = prime_q ? DIFF : WAIT;
        end
        DIFF: begin
          diff_d  = (curr_q > prev_q) ? curr_q - prev_q : prev_q - curr_q;
          state_d = SCALE;
        end
        SCALE: begin
          ovf_d   = full_ovf;
`ifdef SATURATE_EN
          value_d = full_ovf ? '1 : full[WIDTH-1:0];
`else
          value_d = full[WIDTH-1:0];
`endif
          state_d = OUT;
        end
        OUT: state_d = i_ready ? WAIT : OUT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      curr_q    <= '0;
      diff_q    <= '0;
      value_q   <= '0;
      ovf_q     <= 1'b0;
      prime_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      curr_q    <= curr_d;
      diff_q    <= diff_d;
      value_q   <= value_d;
      ovf_q     <= ovf_d;
      prime_q   <= prime_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_value   = value_q;
  assign o_ovf     = ovf_q;
  assign o_overrun = overrun_q;
  assign o_valid   = (state_q == OUT);
  assign o_busy    = (state_q == DIFF) || (state_q == SCALE) || (state_q == OUT);
endmodule

// File: tb/tb_velocity_sample_ctrl.sv
// tb_velocity_sample_ctrl: directed and randomized checks of velocity_sample_ctrl against an arithmetic model.
module tb_velocity_sample_ctrl;
  logic        i_clk, i_rst, i_en, i_ready;
  logic [15:0] i_period, i_value;
  logic [15:0] o_value;
  logic        o_valid, o_ovf, o_overrun, o_busy;
  int          passed = 0, total = 0, ecnt = 0;
  bit          last_tick;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  velocity_sample_ctrl #(.WIDTH(16), .DIV_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_period(i_period), .i_value(i_value),
    .o_value(o_value), .o_valid(o_valid), .i_ready(i_ready), .o_ovf(o_ovf),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  function automatic int unsigned model_full(int unsigned a, int unsigned b);
    int unsigned d;
    d = (a > b) ? a - b : b - a;
    return 3 * d + d / 2 + d / 8;
  endfunction

  function automatic int unsigned model_val(int unsigned a, int unsigned b);
    int unsigned f;
    f = model_full(a, b);
    return (f > 65535 && SAT) ? 65535 : f % 65536;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one clock: predicts whether this edge is a sample tick, then samples at the falling edge
  task automatic step();
    int p;
    p = (i_period == 0) ? 1 : int'(i_period);
    last_tick = i_en && (ecnt % p == p - 1);
    @(posedge i_clk);
    ecnt = i_en ? ecnt + 1 : 0;
    @(negedge i_clk);
  endtask

  task automatic to_tick();
    bit found;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      found = last_tick;
    end
    if (!found) chk("tick_timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input int unsigned ev, input bit eo);
    bit seen;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      seen = o_valid;
    end
    chk({tag, "_valid"}, seen, 1);
    chk({tag, "_value"}, o_value, ev);
    chk({tag, "_ovf"}, o_ovf, eo);
    if (i_ready) begin
      step();
      chk({tag, "_accept"}, o_valid, 0);
    end
  endtask

  initial begin
    int unsigned a, b, c, prv;
    int stable_bad, ovr_bad, ticks, ovrs, vbad;
    i_rst = 1; i_en = 0; i_period = 8; i_value = 0; i_ready = 1;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_value", o_value, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge i_clk);
    i_rst = 0;
    ecnt = 0;
    // prime then first output, exact latency
    i_en = 1; i_value = 100;
    to_tick();
    chk("prime_valid", o_valid, 0);
    chk("prime_busy", o_busy, 0);
    i_value = 188;
    to_tick();
    chk("t1_diff_valid", o_valid, 0);
    chk("t1_diff_busy", o_busy, 1);
    step();
    chk("t1_scale_valid", o_valid, 0);
    step();
    chk("t1_out_valid", o_valid, 1);
    chk("t1_value", o_value, 319);
    chk("t1_ovf", o_ovf, 0);
    step();
    chk("t1_accept", o_valid, 0);
    i_value = 500; to_tick(); expect_out("t2a", model_val(188, 500), 0);
    i_value = 300; to_tick(); expect_out("t2b", 725, 0);
    i_value = 0; to_tick(); expect_out("t3a", model_val(300, 0), 0);
    i_value = 20000; to_tick(); expect_out("t3b", SAT ? 65535 : 6964, 1);
    // backpressure with P=4
    i_en = 0; step();
    i_period = 4; i_en = 1; i_ready = 0; i_value = 1000;
    to_tick();
    i_value = 1100; to_tick(); expect_out("t4", 362, 0);
    stable_bad = 0; ovr_bad = 0; ticks = 0; ovrs = 0;
    for (int i = 0; i < 20; i++) begin
      i_value = 16'($urandom_range(2000, 9000));
      step();
      if (o_valid !== 1'b1 || o_value !== 16'd362) stable_bad++;
      if (o_overrun !== last_tick) ovr_bad++;
      ticks += int'(last_tick);
      ovrs += int'(o_overrun);
    end
    chk("t4_stable", stable_bad, 0);
    chk("t4_ovr_align", ovr_bad, 0);
    chk("t4_ovr_count", ovrs, 5);
    i_value = 1300; i_ready = 1;
    step();
    chk("t4_handshake", o_valid, 0);
    to_tick(); expect_out("t4_next", 725, 0);
    // abort during SCALE, then re-prime
    i_value = 4000; to_tick();
    step();
    chk("t5_in_scale", o_busy, 1);
    i_en = 0;
    vbad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      vbad += int'(o_valid);
    end
    chk("t5_no_valid", vbad, 0);
    chk("t5_idle", o_busy, 0);
    chk("t5_hold", o_value, 725);
    a = $urandom_range(0, 65535); b = $urandom_range(0, 65535);
    i_en = 1; i_value = 16'(a);
    to_tick();
    step(); step();
    chk("t5_reprime_valid", o_valid, 0);
    chk("t5_reprime_busy", o_busy, 0);
    i_value = 16'(b); to_tick(); expect_out("t5_out", model_val(a, b), model_full(a, b) > 65535);
    // async reset while holding an output
    c = b ^ 32'h0100;
    i_ready = 0; i_value = 16'(c); to_tick(); expect_out("t6", model_val(b, c), model_full(b, c) > 65535);
    #2 i_rst = 1;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_value", o_value, 0);
    chk("t6_ovf", o_ovf, 0);
    chk("t6_busy", o_busy, 0);
    @(negedge i_clk);
    i_rst = 0; ecnt = 0; i_ready = 1;
    // randomized periods and samples
    for (int s = 0; s < 3; s++) begin
      i_en = 0; step();
      i_period = 16'($urandom_range(4, 12)); i_en = 1;
      prv = $urandom_range(0, 65535); i_value = 16'(prv);
      to_tick();
      for (int k = 0; k < 8; k++) begin
        c = (k % 3 == 0) ? $urandom_range(0, 65535) : (prv + $urandom_range(0, 4000)) % 65536;
        i_value = 16'(c);
        to_tick();
        expect_out("rnd", model_val(prv, c), model_full(prv, c) > 65535);
        prv = c;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
